// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters decoded into registered sync,
// display-enable, coordinate and start-of-line/frame strobes for a TMDS encoder.
module video_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic        i_enable,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic        o_line_start,
    output logic        o_frame_start
);

    localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST     = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST     = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [11:0] h_q, h_d;
    logic [11:0] v_q, v_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic        in_active;

    assign in_active = (h_q < H_ACT_END) && (v_q < V_ACT_END);

    // Outputs describe the counter value they were decoded from, so they
    // trail (h,v) by one enabled clock; everything freezes when disabled.
    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        x_d           = x_q;
        y_d           = y_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        if (i_enable) begin
            de_d          = in_active;
            hsync_d       = ((h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END)) ? H_POL : ~H_POL;
            vsync_d       = ((v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END)) ? V_POL : ~V_POL;
            x_d           = in_active ? h_q : 12'd0;
            y_d           = in_active ? v_q : 12'd0;
            line_start_d  = (h_q == 12'd0);
            frame_start_d = (h_q == 12'd0) && (v_q == 12'd0);
            if (h_q == H_LAST) begin
                h_d = 12'd0;
                v_d = (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
            end else begin
                h_d = h_q + 12'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            h_q           <= 12'd0;
            v_q           <= 12'd0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            de_q          <= 1'b0;
            x_q           <= 12'd0;
            y_q           <= 12'd0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_de          = de_q;
    assign o_x           = x_q;
    assign o_y           = y_q;
    assign o_line_start  = line_start_q;
    assign o_frame_start = frame_start_q;

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter H_POL, default 0, hsync active level (0 = active-low).
REQ-010 SHALL have parameter V_POL, default 0, vsync active level (0 = active-low).
REQ-011 SHALL have port clk  input  1  pixel clock; single clock domain.
REQ-012 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-013 SHALL have port i_enable  input  1  pixel-advance enable.
REQ-014 SHALL have port o_hsync  output  1  hsync wire level; feeds encoder CD[0].
REQ-015 SHALL have port o_vsync  output  1  vsync wire level; feeds encoder CD[1].
REQ-016 SHALL have port o_de  output  1  display enable; feeds encoder VDE.
REQ-017 SHALL have port o_x  output  12  active-area column; 0 outside active area.
REQ-018 SHALL have port o_y  output  12  active-area row; 0 outside active area.
REQ-019 SHALL have port o_line_start  output  1  one-cycle pulse at start of each line.
REQ-020 SHALL have port o_frame_start  output  1  one-cycle pulse at start of each frame.

Function
REQ-021 SHALL keep internal counters h (0..H_TOT-1) and v (0..V_TOT-1); H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOT likewise.
REQ-022 SHALL, on a cycle with i_enable=1, increment h; at h=H_TOT-1 wrap h to 0 and increment v; at v=V_TOT-1 with h=H_TOT-1 wrap both to 0.
REQ-023 SHALL hold h, v and all outputs unchanged on cycles with i_enable=0 (pulses stay high if already high).
REQ-024 SHALL register every output; outputs on cycle n+1 decode the (h,v) value present on cycle n when i_enable=1 (latency 1 clock).
REQ-025 SHALL drive o_de=1 iff h<H_ACTIVE and v<V_ACTIVE.
REQ-026 SHALL drive o_hsync=H_POL iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~H_POL, for every line including vertical blank.
REQ-027 SHALL drive o_vsync=V_POL iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (all h of those lines), else ~V_POL.
REQ-028 SHALL drive o_x=h and o_y=v when o_de=1, and o_x=o_y=0 otherwise.
REQ-029 SHALL pulse o_line_start for h=0 (every line) and o_frame_start for h=0,v=0.
REQ-030 SHALL size counters at 12 bits; H_TOT and V_TOT up to 4095 SHALL be supported without overflow.
REQ-031 SHALL treat i_reset as dominant over i_enable when both are high.

Reset
REQ-032 SHALL, on the clock edge with i_reset=1, set h=0, v=0, o_de=0, o_hsync=~H_POL, o_vsync=~V_POL, o_x=0, o_y=0, o_line_start=0, o_frame_start=0.
REQ-033 SHALL, with i_enable=1 on the first cycle after reset release, present o_de=1, o_x=0, o_y=0, o_line_start=1, o_frame_start=1 on the following cycle.
REQ-034 SHALL restart from h=0,v=0 on reset asserted mid-frame, with no partial sync pulse extension beyond the reset edge.

Verification
REQ-035 SHALL verify: reset, then i_enable=1 continuously -> cycle 1 after release: o_de=1, x=0, y=0, both start pulses=1; cycle 640: x=639; cycle 641: o_de=0, x=0.
REQ-036 SHALL verify: defaults -> o_hsync low for exactly 96 cycles starting at h=656 each line; 800 cycles between o_line_start pulses.
REQ-037 SHALL verify: defaults -> o_vsync low for lines 490-491 (1600 cycles); o_frame_start period 420000 cycles; o_de high 307200 cycles per frame.
REQ-038 SHALL verify: i_enable toggled 1,0,0,1 pattern during active video -> o_x advances only on enabled cycles; outputs frozen while disabled.
REQ-039 SHALL verify: i_reset pulsed at h=700, v=490 (during hsync/vsync) -> next cycle o_hsync=1, o_vsync=1, o_de=0; sequence restarts per REQ-033.
REQ-040 SHALL verify: H_POL=1, V_POL=1, small timing (H 4/1/2/1, V 3/1/1/1) -> active-high syncs, H_TOT=8, V_TOT=6, wrap at both boundaries correct.
